tpu_host_driver: RTL and testbench

TPU_HOST_DRIVER -- requirements
Module: tpu_host_driver

---
 rtl/tpu_pkg.sv | 25 ++
 rtl/tpu_host_driver_if.sv | 28 ++
 rtl/tpu_host_driver.sv | 153 +++++++++++++++
 tb/tb_tpu_host_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host driver: FSM states, bus address map and
// the helper that forms a per-word slot address.
package tpu_pkg;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    MATMUL = 3'd3,
    WAIT   = 3'd4,
    READ_C = 3'd5
  } state_e;

  localparam int          DEFAULT_DIM = 8;
  localparam logic [15:0] A_BASE      = 16'h0100;
  localparam logic [15:0] B_BASE      = 16'h0200;
  localparam logic [15:0] C_BASE      = 16'h0300;
  localparam logic [15:0] MM_ADDR     = 16'h0400;

  // Each job word occupies one 8-byte slot above its region base.
  function automatic logic [15:0] slot_addr(input logic [15:0] base, input int unsigned k);
    return base + 16'(k << 3);
  endfunction

endpackage

// File: rtl/tpu_host_driver_if.sv
// Job-word input stream, result output stream and TPU bus of the host driver.
// Streams use valid/ready: a word moves on a rising edge where both are high;
// valid must not depend on ready, and data holds while valid && !ready.
interface tpu_host_driver_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_dataIn;
  logic [DATAW-1:0] tpu_dataOut;

  modport master (
    input  in_valid, in_data, out_ready, tpu_dataOut,
    output in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
  );

  modport slave (
    output in_valid, in_data, out_ready, tpu_dataOut,
    input  in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
  );
endinterface

// File: rtl/tpu_host_driver.sv
// Host-side sequencer: streams A, B and C into the TPU, triggers MatMul, waits
// for the array to settle, then reads C back out onto the result stream.
module tpu_host_driver
  import tpu_pkg::*;
#(
  parameter int DIM         = DEFAULT_DIM,
  parameter int ADDRW       = 16,
  parameter int DATAW       = 64,
  parameter int WAIT_CYCLES = 3 * DIM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  tpu_host_driver_if.master   bus,
  output logic                busy,
  output logic                job_done,
  output state_e              dbg_state
);

  localparam int CMAX = (2 * DIM > WAIT_CYCLES) ? 2 * DIM : WAIT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CW-1:0]    w_q, w_d;
  logic             out_valid_q, out_valid_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic             job_done_q, job_done_d;

  logic             in_ready_c;
  logic             r_w_c;
  logic [ADDRW-1:0] addr_c;
  logic [DATAW-1:0] din_c;
  logic [15:0]      base_c;
  logic [CW-1:0]    last_k_c;
  state_e           next_c;

  // Bus activity is also gated by rst_n so nothing is written while reset is held.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    job_done_d  = 1'b0;
    in_ready_c  = 1'b0;
    r_w_c       = 1'b0;
    addr_c      = '0;
    din_c       = '0;
    base_c      = A_BASE;
    last_k_c    = CW'(DIM - 1);
    next_c      = LOAD_B;

    case (state_q)
      LOAD_B:  begin base_c = B_BASE; next_c = LOAD_C; end
      LOAD_C:  begin base_c = C_BASE; next_c = MATMUL; last_k_c = CW'(2 * DIM - 1); end
      READ_C:  begin base_c = C_BASE; next_c = LOAD_A; last_k_c = CW'(2 * DIM - 1); end
      default: ;
    endcase

    if (bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      LOAD_A, LOAD_B, LOAD_C: begin
        in_ready_c = rst_n && !abort;
        if (in_ready_c && bus.in_valid) begin
          r_w_c  = 1'b1;
          addr_c = ADDRW'(slot_addr(base_c, 32'(k_q)));
          din_c  = bus.in_data;
          if (k_q == last_k_c) begin
            state_d = next_c;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      MATMUL: begin
        if (rst_n && !abort) begin
          r_w_c  = 1'b1;
          addr_c = ADDRW'(MM_ADDR);
        end
        state_d = WAIT;
        w_d     = '0;
      end
      WAIT: begin
        if (w_q == CW'(WAIT_CYCLES - 1)) begin
          state_d = READ_C;
          k_d     = '0;
          w_d     = '0;
        end else begin
          w_d = w_q + 1'b1;
        end
      end
      READ_C: begin
        if (rst_n && !abort && (!out_valid_q || bus.out_ready)) begin
          addr_c      = ADDRW'(slot_addr(base_c, 32'(k_q)));
          out_valid_d = 1'b1;
          out_data_d  = bus.tpu_dataOut;
          if (k_q == last_k_c) begin
            state_d    = LOAD_A;
            k_d        = '0;
            job_done_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD_A;
        k_d     = '0;
      end
    endcase

    if (abort) begin
      state_d     = LOAD_A;
      k_d         = '0;
      w_d         = '0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      job_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      k_q         <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      job_done_q  <= job_done_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.tpu_r_w    = r_w_c;
  assign bus.tpu_addr   = addr_c;
  assign bus.tpu_dataIn = din_c;
  assign busy           = !(state_q == LOAD_A && k_q == '0);
  assign job_done       = job_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed bench for tpu_host_driver: expected bus writes and result words are
// queued by the driver tasks and popped by a negedge monitor.
module tb_tpu_host_driver;
  import tpu_pkg::*;

  localparam int DIM   = 8;
  localparam int ADDRW = 16;
  localparam int DATAW = 64;
  localparam int WAITC = 3 * DIM;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   abort = 1'b0;
  logic   busy;
  logic   job_done;
  state_e dbg_state;

  tpu_host_driver_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  tpu_host_driver #(.DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW), .WAIT_CYCLES(WAITC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .job_done  (job_done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [79:0] exp_bus[$];
  logic [63:0] exp_out[$];
  logic [63:0] res_mem[16];
  int n_reads = 0;
  int n_outs  = 0;
  int rd_k    = 0;
  int mm_cyc  = 0;
  bit first_rd_pending = 0;
  bit prev_stall = 0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // TPU model: C region reads return the result table for that slot.
  always_comb begin
    bus.tpu_dataOut = '0;
    if (!bus.tpu_r_w && bus.tpu_addr[15:7] == 9'h006)
      bus.tpu_dataOut = res_mem[bus.tpu_addr[6:3]];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tpu_r_w) begin
        if (exp_bus.size() == 0) fail_now("bus_write_unexpected");
        else chk("bus_write", {bus.tpu_addr, bus.tpu_dataIn}, exp_bus.pop_front());
        if (bus.tpu_addr == MM_ADDR) begin
          mm_cyc = cyc;
          first_rd_pending = 1;
        end
      end else if (bus.tpu_addr != '0) begin
        chk("read_addr", 80'(bus.tpu_addr), 80'(C_BASE + 16'(rd_k * 8)));
        if (first_rd_pending) begin
          chk("wait_len", 80'(cyc - mm_cyc), 80'(WAITC + 1));
          first_rd_pending = 0;
        end
        n_reads++;
        rd_k++;
      end
      if (prev_stall) chk("out_hold", 80'(bus.out_data), 80'(prev_data));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) fail_now("out_unexpected");
        else chk("out_word", 80'(bus.out_data), 80'(exp_out.pop_front()));
        n_outs++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send_word(input logic [63:0] d, input logic [15:0] a);
    int t;
    exp_bus.push_back({a, d});
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic run_job(input int gap_b, input bit expect_out);
    rd_k = 0;
    for (int i = 0; i < DIM; i++) send_word(64'(1) << (8 * i), A_BASE + 16'(8 * i));
    for (int i = 0; i < DIM; i++) begin
      send_word(64'h0202_0202_0202_0202, B_BASE + 16'(8 * i));
      if (i < DIM - 1) begin
        for (int g = 0; g < gap_b; g++) begin
          @(negedge clk);
          chk("gap_idle", {bus.tpu_r_w, bus.tpu_addr, bus.tpu_dataIn}, '0);
          @(posedge clk);
          #1;
        end
      end
    end
    for (int i = 0; i < 2 * DIM; i++) send_word(64'h0, C_BASE + 16'(8 * i));
    exp_bus.push_back({MM_ADDR, 64'h0});
    if (expect_out)
      for (int i = 0; i < 2 * DIM; i++) exp_out.push_back(res_mem[i]);
  endtask

  task automatic wait_done(input int outs_before);
    int t;
    t = 0;
    @(negedge clk);
    while (!job_done && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("job_done_seen", 80'(job_done), 80'(1));
    chk("busy_at_done", 80'(busy), 80'(0));
    repeat (3) @(negedge clk);
    chk("job_done_pulse", 80'(job_done), 80'(0));
    chk("out_drained", 80'(exp_out.size()), 80'(0));
    chk("out_count", 80'(n_outs - outs_before), 80'(2 * DIM));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reads(input int target);
    int t;
    t = 0;
    while (n_reads < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (n_reads < target) fail_now("read_timeout");
  endtask

  initial begin
    int base_r;
    int base_o;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) res_mem[i] = 64'h0002_0002_0002_0002;

    @(negedge clk);
    chk("rst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("rst_out_data", 80'(bus.out_data), 80'(0));
    chk("rst_job_done", 80'(job_done), 80'(0));
    chk("rst_bus", {bus.tpu_r_w, bus.tpu_addr}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 80'(bus.in_ready), 80'(1));
    chk("idle_busy", 80'(busy), 80'(0));
    chk("idle_state", 80'(dbg_state), 80'(LOAD_A));
    @(posedge clk);
    #1;

    // Job 1: identity x twos, back-to-back words, free-flowing output.
    base_o = n_outs;
    run_job(0, 1);
    wait_done(base_o);

    // Job 2: 3-cycle gaps in B, then a 10-cycle output stall mid-readback.
    for (int i = 0; i < 16; i++) res_mem[i] = 64'hC000_0000_0000_0000 | 64'(i);
    base_o = n_outs;
    base_r = n_reads;
    run_job(3, 1);
    wait_reads(base_r + 5);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    base_r = n_reads;
    repeat (10) @(negedge clk);
    chk("stall_no_read", 80'(n_reads), 80'(base_r));
    chk("stall_state", 80'(dbg_state), 80'(READ_C));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_done(base_o);

    // Job 3: abort in WAIT cycle 5 -- nothing may be read back.
    run_job(0, 0);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_in_wait", 80'(dbg_state), 80'(WAIT));
    chk("abort_in_ready", 80'(bus.in_ready), 80'(0));
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 80'(busy), 80'(0));
    chk("abort_state", 80'(dbg_state), 80'(LOAD_A));
    base_r = n_reads;
    repeat (40) @(negedge clk);
    chk("abort_no_read", 80'(n_reads), 80'(base_r));
    chk("abort_no_out", 80'(bus.out_valid), 80'(0));
    @(posedge clk);
    #1;

    // Job 4: full job after the abort.
    for (int i = 0; i < 16; i++) res_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i << 4);
    base_o = n_outs;
    run_job(0, 1);
    wait_done(base_o);

    // Job 5: reset asserted at READ_C k=7.
    for (int i = 0; i < 16; i++) res_mem[i] = 64'h5A00_0000_0000_0000 | 64'(i);
    base_r = n_reads;
    run_job(0, 1);
    wait_reads(base_r + 7);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("mid_rst_bus", {bus.tpu_r_w, bus.tpu_addr}, '0);
    exp_out.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 80'(bus.in_ready), 80'(1));
    chk("post_rst_busy", 80'(busy), 80'(0));
    chk("bus_queue_empty", 80'(exp_bus.size()), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
